// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int INSTR_BYTES = 4;

    // ISSUE: may request; WAIT: one request outstanding;
    // SQUASH: outstanding request is wrong-path, its data will be dropped.
    typedef enum logic [1:0] {
        ISSUE  = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    // Layout of one fetched pair at the default word size.
    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [31:0]          instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Two-entry {pc, instr} FIFO toward decode with flush.
// Flush beats push and pop in the same cycle. While empty the head
// shows the most recently written slot so outputs never go X.
module fetch_queue
    import if_pkg::*;
#(
    parameter int WordSize = WORD_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic [WordSize-1:0] push_pc,
    input  logic [31:0]         push_instr,
    input  logic                pop,
    output logic [1:0]          count,
    output logic [WordSize-1:0] head_pc,
    output logic [31:0]         head_instr
);

    logic [WordSize-1:0] pc_mem    [0:1];
    logic [31:0]         instr_mem [0:1];
    logic                rd_ptr;
    logic                wr_ptr;
    logic                do_pop;
    logic                head_sel;

    assign do_pop = pop && (count != 2'd0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head select: live head when occupied, last written slot when empty.
    always_comb begin
        head_sel   = (count != 2'd0) ? rd_ptr : ~wr_ptr;
        head_pc    = pc_mem[head_sel];
        head_instr = instr_mem[head_sel];
    end

    // Issue is gated on count<2 with one request in flight, so a push
    // into a full queue without a pop must never happen.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && (count == 2'd2) && !do_pop));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns fetch PC, issues one imem request at a
// time, buffers results in a 2-entry queue, and redirects on taken branch.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                   WordSize    = WORD_SIZE,
    parameter logic [WordSize-1:0]  ResetVector = '0,
    parameter int                   InstrBytes  = INSTR_BYTES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [WordSize-1:0] redirect_addr,
    output logic                imem_req,
    output logic [WordSize-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    output logic [WordSize-1:0] if_pc,
    output logic [WordSize-1:0] if_npc,
    output logic [31:0]         if_instr,
    input  logic                id_ready
);

    localparam logic [WordSize-1:0] PcStep = WordSize'(InstrBytes);

    fetch_state_e        state;
    fetch_state_e        state_next;
    logic [WordSize-1:0] fetch_pc;
    logic [WordSize-1:0] req_pc;
    logic                handshake;
    logic                push;
    logic [1:0]          q_count;
    logic [WordSize-1:0] head_pc;
    logic [31:0]         head_instr;
    logic                unused_addr_lsbs;

    // Branch targets are word aligned; the low bits carry no information.
    assign unused_addr_lsbs = ^redirect_addr[1:0];

    assign imem_addr = fetch_pc;
    assign handshake = imem_req && imem_gnt;

    // Next state, request and push decode.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        push       = 1'b0;
        case (state)
            ISSUE: begin
                imem_req = !rst && (q_count != 2'd2) && !redirect;
                if (imem_req && imem_gnt)
                    state_next = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push       = !redirect;
                    state_next = ISSUE;
                end else if (redirect) begin
                    state_next = SQUASH;
                end
            end
            SQUASH: begin
                if (imem_rvalid)
                    state_next = ISSUE;
            end
            default: state_next = ISSUE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ISSUE;
        else
            state <= state_next;
    end

    // Fetch PC: redirect wins; otherwise advance on an accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= ResetVector;
            req_pc   <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_addr[WordSize-1:2], 2'b00};
        end else if (handshake) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PcStep;
        end
    end

    fetch_queue #(.WordSize(WordSize)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_pc    (req_pc),
        .push_instr (imem_rdata),
        .pop        (id_ready),
        .count      (q_count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign if_valid = (q_count != 2'd0);
    assign if_pc    = head_pc;
    assign if_npc   = head_pc + PcStep;
    assign if_instr = head_instr;

endmodule
